// File: rtl/nios2_cpu_pio_in_edge.sv
// ---------------------------------------------------------------------------
// nios2_cpu_pio_in_edge
//
// Edge-capturing parallel input port for the Nios II Avalon-MM bus. Each of
// WIDTH asynchronous inputs (switches, keys) goes through a synchroniser and
// then a per-bit debounce filter. Edges on the debounced level are latched in
// an edge-capture register. That register is gated by an interrupt mask to
// drive a level interrupt.
//
// Register map (word addresses):
//   0 DATA          RO   debounced input level, zero-extended
//   1 DIRECTION     RO   always 0 (input-only port)
//   2 IRQ_MASK      RW   bits [WIDTH-1:0]
//   3 EDGE_CAPTURE  RW1C writing 1 clears a bit; a new edge in the same
//                        cycle keeps the bit set
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register select (word address)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   in_port     raw asynchronous inputs
//   readdata    registered read data, 1 cycle latency, follows address
//   irq         registered level interrupt
// ---------------------------------------------------------------------------
module nios2_cpu_pio_in_edge #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Widen a WIDTH-bit register value onto the 32-bit data bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
  logic [WIDTH-1:0]                  sync_q;
  logic [WIDTH-1:0]                  stable;
  logic [WIDTH-1:0]                  stable_d;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  edge_evt;
  logic [WIDTH-1:0]                  edge_capture;
  logic [WIDTH-1:0]                  irq_mask;
  logic [WIDTH-1:0]                  clr_bits;
  logic                              wr_en;
  logic                              mask_wr;
  logic                              edge_wr;
  logic [31:0]                       rd_next;

  // Only the low WIDTH writedata bits reach any register.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // ---- stage: synchroniser chain ------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // ---- stage: debounce filter ---------------------------------------------
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = sync_q;
    end else begin : g_filter
      localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [WIDTH-1:0][CNT_W-1:0] cnt;
      logic [WIDTH-1:0]            stable_r;

      // The counter measures how long the synchronised input has disagreed
      // with the accepted level. Any agreement restarts the count, so a
      // glitch has to last DEBOUNCE_CYCLES consecutive cycles to be taken.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt      <= '0;
          stable_r <= '0;
        end else begin
          for (int b = 0; b < WIDTH; b++) begin
            if (sync_q[b] == stable_r[b]) begin
              cnt[b] <= '0;
            end else if (cnt[b] == CNT_LAST) begin
              stable_r[b] <= sync_q[b];
              cnt[b]      <= '0;
            end else begin
              cnt[b] <= cnt[b] + CNT_ONE;
            end
          end
        end
      end

      assign stable = stable_r;
    end
  endgenerate

  // ---- stage: edge detect -------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    edge_evt = rise | fall;
    case (EDGE_TYPE)
      0:       edge_evt = rise;
      1:       edge_evt = fall;
      default: edge_evt = rise | fall;
    endcase
  end

  // ---- stage: registers (mask, edge capture) ------------------------------
  assign wr_en    = chipselect & ~write_n;
  assign mask_wr  = wr_en && (address == ADDR_MASK);
  assign edge_wr  = wr_en && (address == ADDR_EDGE);
  assign clr_bits = edge_wr ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (mask_wr) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // The set term is applied after the clear, so a new edge wins over a
      // software clear of the same bit in the same cycle.
      edge_capture <= (edge_capture & ~clr_bits) | edge_evt;
    end
  end

  // ---- stage: read data and interrupt outputs -----------------------------
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next = zext(stable);
      ADDR_DIR:  rd_next = '0;
      ADDR_MASK: rd_next = zext(irq_mask);
      ADDR_EDGE: rd_next = zext(edge_capture);
      default:   rd_next = '0;
    endcase
  end

  // readdata is refreshed every cycle regardless of chipselect; reads have
  // no side effects, so there is nothing to qualify.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= |(edge_capture & irq_mask);
    end
  end

endmodule
